hsid_min_dist_sel: RTL

Downstream consumer of the squared-difference accumulator stream in the HSID datapath. It watches the per-vector final accumulations (`acc_valid && acc_last`) for one pixel compared against a library of reference spectra. It selects the minimum distance and its library index, then presents the result through a valid/ready handshake to the classification/output stage. The accumulator stream has no backpressure, so this block never stalls it; it only drops unexpected samples and flags them.

---
 rtl/hsid_pkg.sv | 14 +
 rtl/hsid_min_dist_sel.sv | 134 +++++++++++++
 2 files changed

// File: rtl/hsid_pkg.sv
// Shared HSID datapath constants and types.
// The min-distance selector state encoding is defined here so other blocks can decode it.
package hsid_pkg;

  localparam int HSID_DATA_WIDTH_ACC = 32;
  localparam int HSID_IDX_WIDTH      = 8;

  typedef enum logic [1:0] {
    HSID_SEL_IDLE,
    HSID_SEL_RUN,
    HSID_SEL_DONE
  } hsid_sel_state_t;

endpackage

// File: rtl/hsid_min_dist_sel.sv
// Tracks the minimum {overflow, distance} key over one pixel's library sweep.
// The result is presented on a valid/ready port; the input stream is never stalled.
module hsid_min_dist_sel
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH_ACC = HSID_DATA_WIDTH_ACC,
  parameter int IDX_WIDTH      = HSID_IDX_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      start,
  input  logic [IDX_WIDTH-1:0]      num_vectors,
  input  logic                      acc_valid,
  input  logic [DATA_WIDTH_ACC-1:0] acc_value,
  input  logic                      acc_last,
  input  logic                      acc_of,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_WIDTH_ACC-1:0] res_min_dist,
  output logic [IDX_WIDTH-1:0]      res_min_idx,
  output logic                      res_of,
  output logic                      drop_err,
  output logic [1:0]                dbg_state
);

  // Result handshake: res_valid is held with all res_* stable until a cycle with
  // res_valid && res_ready; the result is consumed in that cycle.

  hsid_sel_state_t           state_q, state_d;
  logic [IDX_WIDTH-1:0]      num_q, num_d;
  logic [IDX_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      first_q, first_d;
  logic [DATA_WIDTH_ACC-1:0] dist_q, dist_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic                      of_q, of_d;
  logic                      drop_q, drop_d;

  logic                      cand;
  logic [DATA_WIDTH_ACC:0]   key_new;
  logic [DATA_WIDTH_ACC:0]   key_cur;
  logic                      better;

  assign cand    = acc_valid && acc_last;
  // Overflow is the MSB of the key so any overflowed distance loses to a clean one.
  assign key_new = {acc_of, acc_value};
  assign key_cur = {of_q, dist_q};
  assign better  = first_q || (key_new < key_cur);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    dist_d  = dist_q;
    idx_d   = idx_q;
    of_d    = of_q;
    drop_d  = drop_q;

    case (state_q)
      HSID_SEL_IDLE: begin
        if (start && (num_vectors != '0)) begin
          num_d   = num_vectors;
          cnt_d   = '0;
          first_d = 1'b1;
          drop_d  = 1'b0;
          state_d = HSID_SEL_RUN;
        end
        // A candidate coinciding with the accepted start is still a drop.
        if (cand) drop_d = 1'b1;
      end
      HSID_SEL_RUN: begin
        if (cand) begin
          if (better) begin
            dist_d = acc_value;
            of_d   = acc_of;
            idx_d  = cnt_q;
          end
          first_d = 1'b0;
          cnt_d   = cnt_q + IDX_WIDTH'(1);
          if (cnt_q == num_q - IDX_WIDTH'(1)) state_d = HSID_SEL_DONE;
        end
      end
      HSID_SEL_DONE: begin
        if (cand) drop_d = 1'b1;
        if (res_ready) state_d = HSID_SEL_IDLE;
      end
      default: state_d = HSID_SEL_IDLE;
    endcase

    if (clear) begin
      state_d = HSID_SEL_IDLE;
      num_d   = '0;
      cnt_d   = '0;
      first_d = 1'b0;
      dist_d  = '0;
      idx_d   = '0;
      of_d    = 1'b0;
      drop_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HSID_SEL_IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      dist_q  <= '0;
      idx_q   <= '0;
      of_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      dist_q  <= dist_d;
      idx_q   <= idx_d;
      of_q    <= of_d;
      drop_q  <= drop_d;
    end
  end

  assign busy         = (state_q == HSID_SEL_RUN);
  assign res_valid    = (state_q == HSID_SEL_DONE);
  assign res_min_dist = dist_q;
  assign res_min_idx  = idx_q;
  assign res_of       = of_q;
  assign drop_err     = drop_q;
  assign dbg_state    = state_q;

endmodule
